// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot/fetch arbiter.
package imem_ctrl_pkg;
   localparam int IMEM_ADDR_W = 10;
   localparam int WORD_LANES  = 4;
   localparam int LANE_W      = $clog2(WORD_LANES);

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_WRITE = 2'd1,
      ST_RUN   = 2'd2
   } boot_state_t;
endpackage

// File: rtl/imem_word_packer.sv
// Assembles loader bytes into little-endian words; partial words are zero-padded
// because the lanes are cleared after every write.
module imem_word_packer
   import imem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        accept,
   input  logic [7:0]  byte_in,
   input  logic        last_in,
   output logic        word_ready,
   output logic [31:0] word,
   output logic        word_last
);
   logic [LANE_W-1:0] lane;

   assign word_ready = accept && ((lane == LANE_W'(WORD_LANES - 1)) || last_in);

   always_ff @(posedge clk) begin
      if (!rst) begin
         lane      <= '0;
         word      <= '0;
         word_last <= 1'b0;
      end else if (clr) begin
         lane      <= '0;
         word      <= '0;
         word_last <= 1'b0;
      end else if (accept) begin
         word[{lane, 3'b000} +: 8] <= byte_in;
         lane                      <= lane + LANE_W'(1);
         word_last                 <= last_in;
      end
   end
endmodule

// File: rtl/imem_boot_arbiter.sv
// Single-port instruction memory owner: boot loader fills it, fetch reads it afterwards.
//   state    | meaning
//   ST_FILL  | collecting loader bytes into the packer
//   ST_WRITE | one-cycle write of the packed word at the write pointer
//   ST_RUN   | fetch owns the memory port; reboot returns to ST_FILL
module imem_boot_arbiter
   import imem_ctrl_pkg::*;
#(
   parameter int ADDR_W  = IMEM_ADDR_W,
   parameter bit BOOT_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [7:0]        ld_byte,
   input  logic              ld_last,
   input  logic              reboot,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   output logic              if_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              boot_done,
   output logic              ld_overflow,
   output logic [ADDR_W:0]   ld_words
);
   localparam boot_state_t RESET_STATE = BOOT_EN ? ST_FILL : ST_RUN;

   boot_state_t       state, state_nxt;
   logic [ADDR_W-1:0] wptr;
   logic              accept, word_ready, word_last, pack_clr, fetch_err;
   logic [31:0]       pack_word;

   assign accept    = ld_valid && ld_ready;
   assign boot_done = (state == ST_RUN);
   assign fetch_err = (if_addr[1:0] != 2'b00) || ((if_addr >> (ADDR_W + 2)) != 32'd0);

   imem_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr        (pack_clr),
      .accept     (accept),
      .byte_in    (ld_byte),
      .last_in    (ld_last),
      .word_ready (word_ready),
      .word       (pack_word),
      .word_last  (word_last)
   );

   // Handshake outputs are gated by reset so nothing is accepted or written while it is held.
   always_comb begin
      state_nxt = state;
      ld_ready  = 1'b0;
      if_gnt    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = wptr;
      mem_wdata = pack_word;
      pack_clr  = 1'b0;
      case (state)
         ST_FILL: begin
            ld_ready = rst;
            if (accept && word_ready) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            mem_we    = rst;
            pack_clr  = 1'b1;
            state_nxt = word_last ? ST_RUN : ST_FILL;
         end
         ST_RUN: begin
            mem_addr = if_addr[ADDR_W+1:2];
            if_gnt   = rst && if_req && !reboot;
            if (reboot) state_nxt = ST_FILL;
         end
         default: state_nxt = RESET_STATE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= RESET_STATE;
         wptr        <= '0;
         ld_words    <= '0;
         ld_overflow <= 1'b0;
         if_rvalid   <= 1'b0;
         if_rdata    <= '0;
         if_err      <= 1'b0;
      end else begin
         state     <= state_nxt;
         if_rvalid <= if_gnt;
         if_err    <= if_gnt && fetch_err;
         if_rdata  <= (if_gnt && !fetch_err) ? mem_rdata : 32'd0;
         if (state == ST_WRITE) begin
            wptr     <= wptr + ADDR_W'(1);
            ld_words <= ld_words + (ADDR_W + 1)'(1);
            if (&wptr) ld_overflow <= 1'b1;
         end else if (state == ST_RUN && reboot) begin
            wptr        <= '0;
            ld_words    <= '0;
            ld_overflow <= 1'b0;
         end
      end
   end
endmodule

// File: doc/imem_boot_arbiter.md
# imem_boot_arbiter

Owns the single port of the instruction memory and shares it between two requesters: a byte-serial boot loader that fills the memory after reset, and the core's fetch stage that reads instructions afterwards. It packs loader bytes into little-endian words, sequences the writes, and holds fetch off until loading completes. It grants fetch reads once running and returns registered read data with error flags. It sits between the fetch stage, the loader interface, and the word-addressed instruction memory array.

## Interface
- ADDR_W, 10: word-address width; memory depth is 2^ADDR_W words.
- BOOT_EN, 1: 1 = leave reset in boot (loading) mode; 0 = leave reset directly in RUN.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- ld_valid  in  1  loader byte valid.
- ld_ready  out  1  loader byte accepted this cycle when ld_valid && ld_ready.
- ld_byte  in  8  loader data byte, least-significant byte of each word first.
- ld_last  in  1  qualifies the final byte of the image.
- reboot  in  1  in RUN, request re-entry to boot mode.
- if_req  in  1  fetch read request.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  request accepted this cycle.
- if_rvalid  out  1  response valid.
- if_rdata  out  32  response instruction.
- if_err  out  1  response is an error (misaligned or out of range).
- mem_addr  out  ADDR_W  memory word address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory combinational read data for mem_addr.
- boot_done  out  1  high while in RUN.
- ld_overflow  out  1  sticky; image exceeded memory depth.
- ld_words  out  ADDR_W+1  words written by the current or last load.

## Operation
- States: FILL, WRITE, RUN.
- Reset: BOOT_EN=1 enters FILL; BOOT_EN=0 enters RUN.
- Reset values:
  - if_rvalid=0, if_rdata=0, if_err=0, mem_we=0, ld_overflow=0, ld_words=0.
  - Packer lane=0; packer data=0; write pointer=0.
  - boot_done=1 iff the reset state is RUN.
- FILL:
  - ld_ready=1 and if_gnt=0.
  - Each accepted byte goes into lane 0..3.
  - On accepting lane 3, or on accepting any byte with ld_last=1, go to WRITE.
  - Unfilled upper lanes are zero.
- WRITE, exactly one cycle:
  - ld_ready=0, mem_we=1, mem_addr=write pointer, mem_wdata=packed word.
  - Increment the pointer and ld_words, and clear the lanes.
  - Go to RUN if the word was last; otherwise go to FILL.
- Pointer wrap: an increment from 2^ADDR_W-1 wraps to 0 and sets ld_overflow; loading continues.
- RUN:
  - ld_ready=0, mem_we=0.
  - if_gnt = if_req (combinational); mem_addr = if_addr[ADDR_W+1:2].
- Fetch errors:
  - Error when if_addr[1:0]!=0 or any bit of if_addr[31:ADDR_W+2] is nonzero.
  - An errored request is still granted; its response has if_err=1 and if_rdata=0.
- reboot in RUN:
  - if_gnt is forced 0 that cycle and the next state is FILL.
  - On that transition, clear the pointer, ld_words and ld_overflow.
  - An already-granted response still completes on the next cycle.
- In FILL and WRITE, reboot and if_req are ignored.
- Reset asserted mid-load or mid-fetch overrides everything. It discards the partial word and any pending response; nothing is written.

## Timing
- Fetch latency:
  - Grant in cycle N.
  - In cycle N+1, if_rvalid=1 and if_rdata/if_err are registered from cycle N.
  - if_rvalid is 0 when no grant occurred.
- Back-to-back fetch grants every cycle: full throughput, one response per cycle.
- Loader throughput: 4 bytes plus 1 write cycle = 5 cycles per word at best; ld_valid gaps simply stall FILL.
- Entry to RUN:
  - boot_done rises in the cycle after the last WRITE.
  - The first if_gnt is possible in that same cycle.
- ld_byte and ld_last are sampled only on handshake cycles.

## Structure
- Shared package imem_ctrl_pkg holds:
  - the state enum (FILL, WRITE, RUN);
  - the default ADDR_W;
  - the word-lane count constant (4).
- One natural sub-module, imem_word_packer:
  - holds the lane counter and byte assembly;
  - pulses word_ready and carries a last flag;
  - zero-pads partial words.
- The FSM and the fetch response register stay in the top block.

## Test plan
- Boot with BOOT_EN=1: bytes 13 00 00 00 then 93 00 10 00 (ld_last on the final byte). Required:
  - mem 0 = 0x00000013 and mem 1 = 0x00100093, each written via a single mem_we pulse;
  - ld_words=2, boot_done=1 on the next cycle.
- Partial last word: bytes AA BB with ld_last on BB. Required: one write of 0x0000BBAA to address 0, then RUN.
- Fetch in RUN:
  - requests at 0x0, 0x4, 0x8 on consecutive cycles give rvalid on the following three cycles with matching data and if_err=0;
  - a request at 0x2 gives if_err=1, if_rdata=0.
- Out of range with ADDR_W=10: if_addr=0x1000 gives a grant, then if_err=1.
- Reboot: assert reboot in the same cycle as an if_req. Required:
  - if_gnt=0 that cycle;
  - the previous response still delivered;
  - state FILL, ld_words=0, and a new load writes from address 0.
- Reset mid-load after 2 bytes: no mem_we; after reset, lane 0 and pointer 0, and a fresh 4-byte load writes to address 0.
- Overflow with ADDR_W=2: a 5-word image writes addresses 0,1,2,3,0 and sets ld_overflow=1.
